// File: rtl/br_resolve_update_pkg.sv
// Shared widths and bus layouts for the branch-resolve consumer: the FU response
// bus coming in and the predictor-update record handed to BTB/DP.
package br_resolve_update_pkg;

    localparam int SPEC_STATES   = 4;
    localparam int ROB_INDEX_LEN = 6;

    typedef struct packed {
        logic                     valid;
        logic                     isspec;
        logic                     mispred;
        logic [SPEC_STATES-1:0]   spectag;
        logic [ROB_INDEX_LEN-1:0] robidx;
        logic [63:0]              brtarget;
        logic [63:0]              pc;
        logic [2:0]               fetchpcl;
        logic [1:0]               bindx;
        logic [1:0]               brtype;
        logic                     taken;
        logic [1:0]               dp2bc;
        logic [1:0]               btb2bc;
        logic                     btbhit;
        logic                     btbway;
        logic                     is16bit;
    } fubr_resp_t;

    localparam int FUBR_RESULT_LEN = $bits(fubr_resp_t);

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  fetchpcl;
        logic [1:0]  bindx;
        logic [1:0]  brtype;
        logic [63:0] target;
        logic        taken;
        logic [1:0]  dp2bc;
        logic [1:0]  btb2bc;
        logic        btbhit;
        logic        btbway;
        logic        is16bit;
        logic        mispred;
    } bpupd_t;

    localparam int BPUPD_LEN = $bits(bpupd_t);

    // The DP trains on both direction and target, so the mispredict flag rides along.
    function automatic bpupd_t make_update(input fubr_resp_t r);
        bpupd_t u;
        u.pc       = r.pc;
        u.fetchpcl = r.fetchpcl;
        u.bindx    = r.bindx;
        u.brtype   = r.brtype;
        u.target   = r.brtarget;
        u.taken    = r.taken;
        u.dp2bc    = r.dp2bc;
        u.btb2bc   = r.btb2bc;
        u.btbhit   = r.btbhit;
        u.btbway   = r.btbway;
        u.is16bit  = r.is16bit;
        u.mispred  = r.mispred;
        return u;
    endfunction

endpackage

// File: rtl/br_resolve_update_bp_update_fifo.sv
// Predictor-update queue: power-of-two ring buffer with a combinational head so a
// freshly enqueued entry is visible one cycle after it arrives.
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       deq,
    output logic [WIDTH-1:0]           deq_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_enq;
    logic             do_deq;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_deq   = deq && !empty;
    // A full queue still takes a new entry when the head leaves in the same cycle.
    assign do_enq   = enq && (!full || do_deq);
    assign overflow = enq && !do_enq;
    assign deq_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_enq && !clear) begin
            mem[wr_ptr_reg] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_enq) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_deq) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_enq, do_deq})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/br_resolve_update.sv
// Consumes resolved branches: emits kill/redirect on mispredict, spectag release on
// correct speculation, and queues predictor-training records for BTB/DP.
module br_resolve_update
    import br_resolve_update_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Flush,
    input  logic [FUBR_RESULT_LEN-1:0] FUBRresp,
    input  logic [SPEC_STATES-1:0]     Spectag_Valid,
    output logic                       Kill_Enable,
    output logic [SPEC_STATES-1:0]     Kill_VKillMask,
    output logic                       Redirect_Valid,
    output logic [63:0]                Redirect_PC,
    output logic [ROB_INDEX_LEN-1:0]   Redirect_ROBIDX,
    output logic [SPEC_STATES-1:0]     Spectag_Free,
    output logic                       BPUpd_Valid,
    input  logic                       BPUpd_Ready,
    output logic [BPUPD_LEN-1:0]       BPUpd_Bus,
    output logic                       BrIssue_Stall,
    output logic [31:0]                Mispred_Count,
    output logic                       UpdOverflow_Err
);
    localparam int CW = $clog2(UPD_DEPTH) + 1;

    fubr_resp_t    resp;
    logic          tag_dead;
    logic          accept;
    logic          do_kill;
    logic          do_redirect;
    logic          do_free;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;

    assign resp = fubr_resp_t'(FUBRresp);

    // A speculative response whose tag was already killed belongs to a squashed path.
    assign tag_dead    = resp.isspec && (|(resp.spectag & ~Spectag_Valid));
    assign accept      = resp.valid && !Flush && !tag_dead;
    assign do_kill     = accept && resp.isspec && resp.mispred;
    assign do_redirect = accept && resp.mispred;
    assign do_free     = accept && resp.isspec && !resp.mispred;

    bp_update_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH (BPUPD_LEN)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (Flush),
        .enq      (accept),
        .enq_data (make_update(resp)),
        .deq      (BPUpd_Ready),
        .deq_data (BPUpd_Bus),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    assign BPUpd_Valid   = !fifo_empty;
    // Leaves room for the branch being issued now plus the one already in flight.
    assign BrIssue_Stall = (fifo_count >= CW'(UPD_DEPTH - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Kill_Enable     <= 1'b0;
            Kill_VKillMask  <= '0;
            Redirect_Valid  <= 1'b0;
            Redirect_PC     <= '0;
            Redirect_ROBIDX <= '0;
            Spectag_Free    <= '0;
            Mispred_Count   <= '0;
            UpdOverflow_Err <= 1'b0;
        end else begin
            Kill_Enable     <= do_kill;
            Kill_VKillMask  <= do_kill ? resp.spectag : '0;
            Redirect_Valid  <= do_redirect;
            Redirect_PC     <= do_redirect ? resp.brtarget : '0;
            Redirect_ROBIDX <= do_redirect ? resp.robidx : '0;
            Spectag_Free    <= do_free ? resp.spectag : '0;
            if (do_kill && (Mispred_Count != 32'hFFFF_FFFF)) begin
                Mispred_Count <= Mispred_Count + 32'd1;
            end
            if (fifo_overflow && !fifo_full) begin
                UpdOverflow_Err <= UpdOverflow_Err;
            end else if (fifo_overflow) begin
                UpdOverflow_Err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_br_resolve_update.sv
// Directed bench for br_resolve_update: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_br_resolve_update;
    import br_resolve_update_pkg::*;

    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     Flush = 1'b0;
    fubr_resp_t               resp;
    logic [SPEC_STATES-1:0]   sv;
    logic                     Kill_Enable;
    logic [SPEC_STATES-1:0]   Kill_VKillMask;
    logic                     Redirect_Valid;
    logic [63:0]              Redirect_PC;
    logic [ROB_INDEX_LEN-1:0] Redirect_ROBIDX;
    logic [SPEC_STATES-1:0]   Spectag_Free;
    logic                     BPUpd_Valid;
    logic                     BPUpd_Ready;
    logic [BPUPD_LEN-1:0]     BPUpd_Bus;
    logic                     BrIssue_Stall;
    logic [31:0]              Mispred_Count;
    logic                     UpdOverflow_Err;

    br_resolve_update #(.UPD_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Flush           (Flush),
        .FUBRresp        (resp),
        .Spectag_Valid   (sv),
        .Kill_Enable     (Kill_Enable),
        .Kill_VKillMask  (Kill_VKillMask),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_PC     (Redirect_PC),
        .Redirect_ROBIDX (Redirect_ROBIDX),
        .Spectag_Free    (Spectag_Free),
        .BPUpd_Valid     (BPUpd_Valid),
        .BPUpd_Ready     (BPUpd_Ready),
        .BPUpd_Bus       (BPUpd_Bus),
        .BrIssue_Stall   (BrIssue_Stall),
        .Mispred_Count   (Mispred_Count),
        .UpdOverflow_Err (UpdOverflow_Err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model state: registered strobes plus the pending update records.
    logic                     m_kill, m_redir, m_err;
    logic [SPEC_STATES-1:0]   m_mask, m_free;
    logic [63:0]              m_pc;
    logic [ROB_INDEX_LEN-1:0] m_rob;
    logic [31:0]              m_cnt;
    bpupd_t                   m_q[$];

    function automatic bpupd_t to_upd(input fubr_resp_t r);
        bpupd_t u;
        u = '0;
        u.pc = r.pc;           u.fetchpcl = r.fetchpcl; u.bindx = r.bindx;
        u.brtype = r.brtype;   u.target = r.brtarget;   u.taken = r.taken;
        u.dp2bc = r.dp2bc;     u.btb2bc = r.btb2bc;     u.btbhit = r.btbhit;
        u.btbway = r.btbway;   u.is16bit = r.is16bit;   u.mispred = r.mispred;
        return u;
    endfunction

    task automatic model_clear();
        m_kill = 0; m_redir = 0; m_err = 0; m_mask = '0; m_free = '0;
        m_pc = '0; m_rob = '0; m_cnt = '0;
        m_q.delete();
    endtask

    initial model_clear();

    always @(posedge clk) begin
        bit acc, deq, spec_kill;
        int n;
        if (rst_n) begin
            n   = m_q.size();
            deq = (n > 0) && BPUpd_Ready;
            acc = resp.valid && !Flush && !(resp.isspec && ((resp.spectag & ~sv) != '0));
            if (Flush) begin
                m_q.delete();
            end else begin
                if (deq) void'(m_q.pop_front());
                if (acc) begin
                    if (n < DEPTH || deq) m_q.push_back(to_upd(resp));
                    else m_err = 1;
                end
            end
            spec_kill = acc && resp.isspec && resp.mispred;
            m_kill  = spec_kill;
            m_mask  = spec_kill ? resp.spectag : '0;
            m_redir = acc && resp.mispred;
            m_pc    = m_redir ? resp.brtarget : '0;
            m_rob   = m_redir ? resp.robidx : '0;
            m_free  = (acc && resp.isspec && !resp.mispred) ? resp.spectag : '0;
            if (spec_kill && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            chk("kill", Kill_Enable, m_kill);
            chk("kill_mask", Kill_VKillMask, m_mask);
            chk("redir", Redirect_Valid, m_redir);
            chk("redir_pc", Redirect_PC, m_pc);
            chk("redir_rob", Redirect_ROBIDX, m_rob);
            chk("free", Spectag_Free, m_free);
            chk("upd_valid", BPUpd_Valid, m_q.size() > 0);
            chk("upd_bus", BPUpd_Bus, (m_q.size() > 0) ? m_q[0] : bpupd_t'(0));
            chk("stall", BrIssue_Stall, m_q.size() >= DEPTH - 2);
            chk("mcount", Mispred_Count, m_cnt);
            chk("ovf_err", UpdOverflow_Err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input bit isspec, input bit mispred, input logic [SPEC_STATES-1:0] tag,
                            input logic [63:0] tgt, input logic [63:0] pc, input logic [ROB_INDEX_LEN-1:0] rob);
        resp = '0;
        resp.valid = 1'b1;    resp.isspec = isspec;   resp.mispred = mispred;
        resp.spectag = tag;   resp.robidx = rob;      resp.brtarget = tgt;
        resp.pc = pc;         resp.fetchpcl = pc[3:1]; resp.bindx = pc[5:4];
        resp.brtype = isspec ? 2'd1 : 2'd2;           resp.taken = !mispred;
        resp.dp2bc = pc[9:8]; resp.btb2bc = pc[11:10]; resp.btbhit = pc[12];
        resp.btbway = pc[13]; resp.is16bit = pc[1];
    endtask

    task automatic idle();
        resp = '0;
    endtask

    bpupd_t head;

    initial begin
        idle();
        sv = '1;
        BPUpd_Ready = 1'b1;
        #1;
        rst_n = 1'b0;
        model_clear();
        repeat (2) step();
        chk("lit_reset_kill", Kill_Enable, 1'b0);
        chk("lit_reset_valid", BPUpd_Valid, 1'b0);
        rst_n = 1'b1;
        step();

        // Speculative mispredict
        set_resp(1, 1, 4'b0010, 64'h8000_0040, 64'h1000, 6'd5);
        step(); idle();
        head = BPUpd_Bus;
        chk("lit_mp_kill", Kill_Enable, 1'b1);
        chk("lit_mp_mask", Kill_VKillMask, 4'b0010);
        chk("lit_mp_pc", Redirect_PC, 64'h8000_0040);
        chk("lit_mp_rob", Redirect_ROBIDX, 6'd5);
        chk("lit_mp_qvalid", BPUpd_Valid, 1'b1);
        chk("lit_mp_qpc", head.pc, 64'h1000);
        chk("lit_mp_qmis", head.mispred, 1'b1);
        chk("lit_mp_cnt", Mispred_Count, 32'd1);

        // Correct prediction
        set_resp(1, 0, 4'b0100, 64'h2040, 64'h2000, 6'd6);
        step(); idle();
        head = BPUpd_Bus;
        chk("lit_ok_free", Spectag_Free, 4'b0100);
        chk("lit_ok_kill", Kill_Enable, 1'b0);
        chk("lit_ok_qpc", head.pc, 64'h2000);
        chk("lit_ok_qmis", head.mispred, 1'b0);
        step();
        chk("lit_ok_drained", BPUpd_Valid, 1'b0);

        // Response carrying an already-killed tag
        sv = 4'b0111;
        set_resp(1, 1, 4'b1000, 64'h3040, 64'h3000, 6'd7);
        step(); idle(); sv = '1;
        chk("lit_drop_kill", Kill_Enable, 1'b0);
        chk("lit_drop_free", Spectag_Free, 4'b0000);
        chk("lit_drop_valid", BPUpd_Valid, 1'b0);

        // Non-speculative JAL with BTB miss: redirect only
        set_resp(0, 1, 4'b0000, 64'h4080, 64'h4000, 6'd8);
        step(); idle();
        chk("lit_jal_redir", Redirect_Valid, 1'b1);
        chk("lit_jal_pc", Redirect_PC, 64'h4080);
        chk("lit_jal_kill", Kill_Enable, 1'b0);
        step();

        // Fill with Ready low, then overflow
        BPUpd_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_resp(1, 0, 4'b0001, 64'h50 + 64'(i), 64'h100 * 64'(i + 1), 6'(i));
            step();
            chk("lit_fill_stall", BrIssue_Stall, (i + 1) >= 2);
        end
        set_resp(1, 0, 4'b0001, 64'h55, 64'h500, 6'd9);
        step(); idle();
        chk("lit_ovf_err", UpdOverflow_Err, 1'b1);
        chk("lit_ovf_stall", BrIssue_Stall, 1'b1);
        BPUpd_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            head = BPUpd_Bus;
            chk("lit_drain_pc", head.pc, 64'h100 * 64'(i + 1));
            step();
        end
        chk("lit_drain_empty", BPUpd_Valid, 1'b0);

        // Mispredict coincident with flush
        BPUpd_Ready = 1'b0;
        set_resp(1, 0, 4'b0001, 64'h660, 64'h600, 6'd1);
        step();
        set_resp(1, 1, 4'b0010, 64'h8000_0100, 64'h700, 6'd9);
        Flush = 1'b1;
        step(); idle(); Flush = 1'b0;
        chk("lit_fl_kill", Kill_Enable, 1'b0);
        chk("lit_fl_redir", Redirect_Valid, 1'b0);
        chk("lit_fl_valid", BPUpd_Valid, 1'b0);
        chk("lit_fl_cnt", Mispred_Count, 32'd1);
        chk("lit_fl_err", UpdOverflow_Err, 1'b1);

        // Back-to-back mispredicts on surviving tags
        BPUpd_Ready = 1'b1;
        set_resp(1, 1, 4'b0001, 64'h9000, 64'h800, 6'd10);
        step();
        chk("lit_b2b_mask0", Kill_VKillMask, 4'b0001);
        set_resp(1, 1, 4'b0010, 64'h9100, 64'h900, 6'd11);
        step(); idle();
        chk("lit_b2b_mask1", Kill_VKillMask, 4'b0010);
        chk("lit_b2b_pc1", Redirect_PC, 64'h9100);
        chk("lit_b2b_cnt", Mispred_Count, 32'd3);
        step();

        // Reset with entries queued
        BPUpd_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_resp(1, 1, 4'b0100, 64'hA000 + 64'(i), 64'hA00 + 64'(i * 16), 6'(i));
            step();
        end
        idle();
        chk("lit_pre_rst_valid", BPUpd_Valid, 1'b1);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("lit_rst_kill", Kill_Enable, 1'b0);
        chk("lit_rst_mask", Kill_VKillMask, 4'b0000);
        chk("lit_rst_redir", Redirect_Valid, 1'b0);
        chk("lit_rst_pc", Redirect_PC, 64'h0);
        chk("lit_rst_valid", BPUpd_Valid, 1'b0);
        chk("lit_rst_bus", BPUpd_Bus, '0);
        chk("lit_rst_stall", BrIssue_Stall, 1'b0);
        chk("lit_rst_cnt", Mispred_Count, 32'd0);
        chk("lit_rst_err", UpdOverflow_Err, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
